// File: rtl/time_tmr_issue_if.sv
// Handshake bundle for the time-redundant TMR issue stage: the upstream
// element stream and the downstream stream of tagged copies.
interface time_tmr_issue_if #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
);
  // Upstream side
  DataType             data_i;
  logic                valid_i;
  logic                ready_o;
  // Downstream side
  DataType             data_o;
  logic [IDSize-1:0]   id_o;
  logic [1:0]          replica_o;
  logic                valid_o;
  logic                ready_i;

  // The issue stage itself
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, id_o, replica_o, valid_o
  );

  // The environment around the issue stage (upstream producer + downstream voter)
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, id_o, replica_o, valid_o
  );
endinterface

// File: rtl/time_tmr_issue.sv
// Time-redundant TMR issue stage: accepts one element, then issues it three
// times back-to-back tagged with a per-element ID so the downstream voter can
// separate consecutive elements. With enable_i low it is a plain wire.
module time_tmr_issue #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  time_tmr_issue_if.slave bus
);

  typedef enum logic {
    IDLE,  // buffer empty
    SEND   // buffer full, issuing copy cnt_q
  } state_e;

  localparam logic [1:0] LastCopy = 2'd2;

  state_e            state_q, state_d;
  DataType           data_q, data_d;
  logic [IDSize-1:0] id_q, id_d;
  logic [IDSize-1:0] id_next_q, id_next_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              accept;

  // Next-state logic and output muxing for both replicate and bypass modes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d       = state_q;
    data_d        = data_q;
    id_d          = id_q;
    id_next_d     = id_next_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    bus.data_o    = data_q;
    bus.id_o      = id_q;
    bus.replica_o = 2'd0;
    bus.valid_o   = 1'b0;
    bus.ready_o   = 1'b0;

    if (!enable_i) begin
      // Bypass: straight wire; any held element is dropped, the ID is frozen.
      bus.data_o  = bus.data_i;
      bus.valid_o = bus.valid_i;
      bus.ready_o = bus.ready_i;
      bus.id_o    = id_next_q;
      state_d     = IDLE;
      cnt_d       = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bus.ready_o = 1'b1;
          accept      = bus.valid_i;
        end
        SEND: begin
          bus.valid_o   = 1'b1;
          bus.replica_o = cnt_q;
          if (bus.ready_i) begin
            if (cnt_q != LastCopy) begin
              cnt_d = cnt_q + 2'd1;
            end else begin
              // Last copy leaving: the buffer frees up this very cycle, so a
              // waiting element can be reloaded without a bubble.
              bus.ready_o = 1'b1;
              accept      = bus.valid_i;
              if (!bus.valid_i) state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        data_d    = bus.data_i;
        id_d      = id_next_q;
        id_next_d = id_next_q + IDSize'(1);
        cnt_d     = 2'd0;
        state_d   = SEND;
      end
    end
  end

  // State and element buffer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the data buffer is a single register, not a memory, so it is reset to keep data_o defined after reset.
      state_q   <= IDLE;
      data_q    <= '0;
      id_q      <= '0;
      id_next_q <= '0;
      cnt_q     <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      data_q    <= data_d;
      id_q      <= id_d;
      id_next_q <= id_next_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_time_tmr_issue.sv
// Directed bench for time_tmr_issue. Two instances share the same stimulus:
// dut_a with a 2-bit ID and dut_b with a 1-bit ID, so ID wrap is visible on
// both widths. Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_time_tmr_issue;
  typedef logic [7:0] byte_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  enable;
  int    n_cmp = 0;
  int    n_err = 0;
  byte_t elems [0:2];

  time_tmr_issue_if #(.DataType(byte_t), .IDSize(2)) bus_a ();
  time_tmr_issue_if #(.DataType(byte_t), .IDSize(1)) bus_b ();

  assign bus_b.data_i  = bus_a.data_i;
  assign bus_b.valid_i = bus_a.valid_i;
  assign bus_b.ready_i = bus_a.ready_i;

  time_tmr_issue #(.DataType(byte_t), .IDSize(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_a)
  );
  time_tmr_issue #(.DataType(byte_t), .IDSize(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Observed vectors: {valid_o, ready_o, data_o, id_o, replica_o}
  function automatic logic [13:0] obs_a();
    return {bus_a.valid_o, bus_a.ready_o, bus_a.data_o, bus_a.id_o, bus_a.replica_o};
  endfunction
  function automatic logic [12:0] obs_b();
    return {bus_b.valid_o, bus_b.ready_o, bus_b.data_o, bus_b.id_o, bus_b.replica_o};
  endfunction

  task automatic drive(input logic en, input logic v, input byte_t d, input logic r);
    @(negedge clk);
    enable        = en;
    bus_a.valid_i = v;
    bus_a.data_i  = d;
    bus_a.ready_i = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    enable        = 1'b1;
    bus_a.valid_i = 1'b0;
    bus_a.data_i  = 8'h00;
    bus_a.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] ea;
    logic [12:0] eb;
    do_reset();
    #1;
    ea = {1'b0, 1'b1, 8'h00, 2'd0, 2'd0};
    eb = {1'b0, 1'b1, 8'h00, 1'b0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL reset_a got %h want %h", obs_a(), ea); end
    n_cmp++;
    if (obs_b() !== eb) begin n_err++; $display("FAIL reset_b got %h want %h", obs_b(), eb); end
  endtask

  task automatic test_single();
    logic [13:0] ea;
    do_reset();
    drive(1'b1, 1'b1, 8'hA5, 1'b1);
    ea = {1'b0, 1'b1, 8'h00, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL single_accept got %h want %h", obs_a(), ea); end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      ea = {1'b1, (k == 3), 8'hA5, 2'd0, 2'(k - 1)};
      n_cmp++;
      if (obs_a() !== ea) begin n_err++; $display("FAIL single_copy%0d got %h want %h", k - 1, obs_a(), ea); end
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b0, 1'b1, 8'hA5, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL single_done got %h want %h", obs_a(), ea); end
  endtask

  // Streams elems[0..n-1] with ready_i=1, offering the next element as soon as
  // the current one is accepted.
  task automatic run_stream(input string name, input int n);
    logic [13:0] ea;
    logic [12:0] eb;
    int          e;
    logic        v;
    do_reset();
    drive(1'b1, 1'b1, elems[0], 1'b1);
    ea = {1'b0, 1'b1, 8'h00, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL %s_accept got %h want %h", name, obs_a(), ea); end
    for (int k = 1; k <= 3 * n; k++) begin
      e = (k - 1) / 3;
      v = (e + 1 < n);
      drive(1'b1, v, v ? elems[e + 1] : 8'h00, 1'b1);
      ea = {1'b1, (k % 3 == 0), elems[e], 2'(e), 2'((k - 1) % 3)};
      eb = {1'b1, (k % 3 == 0), elems[e], 1'(e), 2'((k - 1) % 3)};
      n_cmp++;
      if (obs_a() !== ea) begin n_err++; $display("FAIL %s_a_cycle%0d got %h want %h", name, k, obs_a(), ea); end
      n_cmp++;
      if (obs_b() !== eb) begin n_err++; $display("FAIL %s_b_cycle%0d got %h want %h", name, k, obs_b(), eb); end
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b0, 1'b1, elems[n - 1], 2'(n - 1), 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL %s_idle got %h want %h", name, obs_a(), ea); end
  endtask

  task automatic test_stream();
    elems[0] = 8'h11; elems[1] = 8'h22; elems[2] = 8'h33;
    run_stream("stream", 3);
  endtask

  task automatic test_equal_data();
    elems[0] = 8'h55; elems[1] = 8'h55; elems[2] = 8'h00;
    run_stream("equal", 2);
  endtask

  task automatic test_stall();
    logic [13:0] ea;
    do_reset();
    drive(1'b1, 1'b1, 8'h3C, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b0, 8'h3C, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL stall_copy0 got %h want %h", obs_a(), ea); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      ea = {1'b1, 1'b0, 8'h3C, 2'd0, 2'd1};
      n_cmp++;
      if (obs_a() !== ea) begin n_err++; $display("FAIL stall_hold%0d got %h want %h", k, obs_a(), ea); end
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b0, 8'h3C, 2'd0, 2'd1};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL stall_release got %h want %h", obs_a(), ea); end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b1, 8'h3C, 2'd0, 2'd2};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL stall_copy2 got %h want %h", obs_a(), ea); end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b0, 1'b1, 8'h3C, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL stall_idle got %h want %h", obs_a(), ea); end
  endtask

  // Runs after test_stall: one element issued, so id_next is 1 on both DUTs.
  task automatic test_bypass();
    logic [13:0] ea;
    logic [12:0] eb;
    logic        vv [0:4];
    logic        rr [0:4];
    byte_t       dd [0:4];
    vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    dd = '{8'h12, 8'hFE, 8'h00, 8'h81, 8'h5A};
    // Element with ID 1 starts issuing and is then dropped by the bypass.
    drive(1'b1, 1'b1, 8'hC3, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b0, 8'hC3, 2'd1, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL bypass_pre got %h want %h", obs_a(), ea); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, vv[k], dd[k], rr[k]);
      ea = {vv[k], rr[k], dd[k], 2'd2, 2'd0};
      eb = {vv[k], rr[k], dd[k], 1'b0, 2'd0};
      n_cmp++;
      if (obs_a() !== ea) begin n_err++; $display("FAIL bypass_a%0d got %h want %h", k, obs_a(), ea); end
      n_cmp++;
      if (obs_b() !== eb) begin n_err++; $display("FAIL bypass_b%0d got %h want %h", k, obs_b(), eb); end
    end
    // Re-enable: IDLE immediately, held registers untouched by the bypass.
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    ea = {1'b0, 1'b1, 8'hC3, 2'd1, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL reenable_idle got %h want %h", obs_a(), ea); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      ea = {1'b1, (k == 2), 8'h77, 2'd2, 2'(k)};
      eb = {1'b1, (k == 2), 8'h77, 1'b0, 2'(k)};
      n_cmp++;
      if (obs_a() !== ea) begin n_err++; $display("FAIL reenable_a%0d got %h want %h", k, obs_a(), ea); end
      n_cmp++;
      if (obs_b() !== eb) begin n_err++; $display("FAIL reenable_b%0d got %h want %h", k, obs_b(), eb); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [13:0] ea;
    logic [12:0] eb;
    do_reset();
    // Elements 0x40,0x43,0x46,0x49 accepted on cycles 0,3,6,9 (IDs 0..3).
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 8'(8'h40 + k), 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b0, 8'h49, 2'd3, 2'd0};
    eb = {1'b1, 1'b0, 8'h49, 1'b1, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL rstmid_id3 got %h want %h", obs_a(), ea); end
    n_cmp++;
    if (obs_b() !== eb) begin n_err++; $display("FAIL rstmid_b got %h want %h", obs_b(), eb); end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    ea = {1'b1, 1'b0, 8'h49, 2'd3, 2'd1};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL rstmid_copy1 got %h want %h", obs_a(), ea); end
    rst = 1'b1;
    #1;
    ea = {1'b0, 1'b1, 8'h00, 2'd0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL rstmid_async got %h want %h", obs_a(), ea); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h9A, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    ea = {1'b1, 1'b0, 8'h9A, 2'd0, 2'd0};
    eb = {1'b1, 1'b0, 8'h9A, 1'b0, 2'd0};
    n_cmp++;
    if (obs_a() !== ea) begin n_err++; $display("FAIL rstmid_next_a got %h want %h", obs_a(), ea); end
    n_cmp++;
    if (obs_b() !== eb) begin n_err++; $display("FAIL rstmid_next_b got %h want %h", obs_b(), eb); end
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b1;
    bus_a.valid_i = 1'b0;
    bus_a.data_i  = 8'h00;
    bus_a.ready_i = 1'b1;
    test_reset();
    test_single();
    test_stream();
    test_equal_data();
    test_stall();
    test_bypass();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/time_tmr_issue.md
# time_tmr_issue

Upstream companion of the time-redundant TMR voting stage. Accepts one element per upstream handshake, stores it, and issues it three times back-to-back downstream, each copy tagged with the same element ID. The ID advances per element, so the downstream voter can tell consecutive elements apart even when their data is equal. When disabled, the block becomes a transparent pass-through.

## Interface
- DataType, logic: payload type being replicated.
- IDSize, 1: ID width. Must equal the IDSize of the downstream voting stage. Use 1 for in-order paths; larger values for out-of-order paths.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- enable_i  in  1  1 = replicate; 0 = bypass.
- data_i  in  DataType  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DataType  downstream payload (current copy).
- id_o  out  IDSize  ID of the current copy.
- replica_o  out  2  copy index 0/1/2 of the current copy; 0 in bypass.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.

## Operation
- Registers:
  - data_q: holds the element.
  - id_q: ID of the held element.
  - id_next_q: ID for the next accepted element.
  - cnt_q: 2-bit copy index.
  - state_q.
- States:
  - IDLE: buffer empty.
  - SEND: buffer full, issuing copy cnt_q.
- IDLE, enable_i=1:
  - Outputs: ready_o=1, valid_o=0.
  - On valid_i:
    - data_q←data_i; id_q←id_next_q; id_next_q←id_next_q+1 (mod 2^IDSize, wraps).
    - cnt_q←0; go to SEND.
- SEND, enable_i=1:
  - Outputs: valid_o=1, data_o=data_q, id_o=id_q, replica_o=cnt_q.
  - On ready_i with cnt_q<2: cnt_q←cnt_q+1.
  - On ready_i with cnt_q==2 (last copy):
    - ready_o=1 in the same cycle.
    - If valid_i: load the new element exactly as in IDLE and stay in SEND with cnt_q←0.
    - Else go to IDLE.
  - ready_o=0 in every other SEND cycle.
- Downstream stall (ready_i=0): data_o, id_o and replica_o are held stable and valid_o stays 1. AXI-style: valid_o is never withdrawn until handshake.
- Bypass (enable_i=0):
  - Combinational pass-through: data_o=data_i, valid_o=valid_i, ready_o=ready_i.
  - id_o=id_next_q, replica_o=0.
  - Next cycle: state_q←IDLE, cnt_q←0. Any held element is dropped.
  - id_next_q is not incremented in bypass.
- Switching enable_i from 0 to 1: takes effect in the same cycle, starting from IDLE.
- Outputs in IDLE when enabled: data_o=data_q, id_o=id_q, replica_o=0, all with valid_o=0.

## Timing
- Reset (async assert, sync release):
  - state_q=IDLE, cnt_q=0, data_q='0, id_q=0, id_next_q=0.
  - Outputs with enable_i=1: valid_o=0, ready_o=1, data_o='0, id_o=0, replica_o=0.
- Latency: the first copy is valid the cycle after upstream acceptance. data_i never flows combinationally to data_o while enabled.
- Throughput with ready_i held at 1: one element per 3 cycles, with no bubble between elements (reload on last-copy handshake).
- ready_o has a combinational dependency on ready_i only in SEND with cnt_q==2 (and in bypass). valid_o does not depend on valid_i while enabled.
- ID wrap: with IDSize=1, IDs alternate 0,1,0,1…; with IDSize=2: 0,1,2,3,0…
- Reset mid-SEND: the held element is discarded and the ID restarts at 0.
- enable_i dropping mid-SEND: remaining copies are lost. Upstream must not rely on completion.

## Test plan
- Reset, then enable=1, ready_i=1, single element 0xA5 -> valid_o for exactly 3 cycles starting 1 cycle after acceptance. data_o=0xA5, id_o=0, replica_o=0,1,2. ready_o=0 during copies 0/1.
- Continuous stream 0x11,0x22,0x33 with ready_i=1, IDSize=2 -> 9 consecutive valid cycles, no gaps. IDs 0,0,0,1,1,1,2,2,2. ready_o pulses on cycles 3, 6 and 9.
- Equal data 0x55 twice, IDSize=1 -> six copies of 0x55 with id_o 0,0,0,1,1,1.
- ready_i=0 for 4 cycles during copy 1 -> data_o, id_o and replica_o=1 held stable, valid_o=1 throughout, ready_o=0. Copy 2 follows once ready_i returns.
- enable_i=0 with random valid_i/ready_i/data_i -> outputs mirror the inputs in the same cycle, replica_o=0, id_o unchanged. After re-enable, the next element gets the pre-bypass id_next_q.
- Assert rst_i during copy 1 of an element with ID 3 -> valid_o=0 and ready_o=1 immediately. The next element is issued with ID 0.
